cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Command-issue stage directly upstream of the DDR3 command/address PHY.
- Accepts encoded DDR3 commands over a valid/ready handshake, each with a per-command NOP gap.
- Drives the PHY's paired-slot inputs (2 bits per signal per clk_div): command in the first clk slot, NOP in the second.
- Controls CKE/ODT levels and the tristate of the command/address bus, and reports sequence completion.

Parameters:
- ADDRESS_NUMBER, 15, DDR3 address width.
- DELAY_WIDTH, 10, width of the per-command NOP-gap counter.

Ports:
- clk_div  in  1  half-rate clock shared with the PHY.
- rst_n  in  1  asynchronous reset, active low.
- en  in  1  sequencer enable.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  3  {RAS,CAS,WE} active-low code: 0 MRS, 1 REF, 2 PRE, 3 ACT, 4 WR, 5 RD, 6 ZQC, 7 NOP.
- cmd_ba  in  3  bank address.
- cmd_a  in  ADDRESS_NUMBER  row/column/mode address.
- cmd_cke  in  1  CKE level applied from this command on.
- cmd_odt  in  1  ODT level applied from this command on.
- cmd_dly  in  DELAY_WIDTH  number of extra NOP clk_div cycles after the command.
- cmd_last  in  1  final command of the sequence.
- out_a  out  2*ADDRESS_NUMBER  address pairs to the PHY.
- out_ba  out  6  bank address pairs.
- out_we, out_ras, out_cas  out  2 each  command pairs.
- out_cke, out_odt  out  2 each  CKE/ODT pairs.
- out_tri  out  2  tristate pair to the PHY.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Slot order: for every pair, bit [2i] is the first (earlier) clk slot and bit [2i+1] is the second.
- All outputs are registered on clk_div.

Reset (rst_n low, asynchronous, also mid-operation):
- out_a = 0, out_ba = 0.
- out_we / out_ras / out_cas = 2'b11 (NOP).
- out_cke = 2'b00, out_odt = 2'b00, out_tri = 2'b11.
- busy = 0, done = 0, counter = 0, state = IDLE.
- A command in flight is discarded.

Handshake:
- cmd_ready = en & (count == 0) & ~done_pending. Combinational from registers and en only; never depends on cmd_valid.

States:
- IDLE: NOP on both slots, address/bank hold their last values. On accept -> ISSUE.
- ISSUE (one cycle, cycle N+1 after accept in cycle N):
  - out_ras/cas/we = {1, cmd_op bit}: the first slot carries the opcode bit, the second slot is 1.
  - out_a / out_ba carry cmd_a / cmd_ba in both slots.
  - out_cke / out_odt = both slots at cmd_cke / cmd_odt. These levels are sticky until the next command.
  - The counter loads cmd_dly.
  - Next state: if cmd_dly == 0 and cmd_last == 0, another command may be accepted in this same cycle (back-to-back, one command per clk_div). If cmd_dly == 0 and cmd_last == 1 -> DONE. Otherwise -> WAIT.
- WAIT: NOP on both slots, address held, counter decrements by 1 each cycle.
  - At counter == 1 -> IDLE, or DONE if the latched last flag is set.
  - cmd_ready rises in the cycle the counter reaches 0.
- DONE: done = 1 for exactly one cycle, busy drops in the same cycle, -> IDLE.

busy:
- Set in the cycle after the first accept.
- Cleared together with the done pulse.

en behaviour:
- en low mid-sequence: the current command and its WAIT complete; no new accept occurs; busy stays high until the next cmd_last completes.
- out_tri = 2'b11 only when en = 0 and busy = 0; otherwise 2'b00. It updates registered, one cycle after en changes.

Edge cases:
- cmd_op = 7 (NOP) is accepted as a timed NOP carrying the cke/odt update.
- cmd_dly at its maximum, 2^DELAY_WIDTH - 1, gives exactly that many WAIT cycles, with no counter wrap.
- cmd_valid high while cmd_ready is low: the command is held off with no side effects.

Test Plan:
- Reset, then en = 1, no valid -> out_tri = 00 one cycle later, ras/cas/we = 11, cke = 00, busy = 0, cmd_ready = 1.
- ACT (op 3), ba = 5, a = 0x1234, dly = 3, last = 1 -> next cycle: ras = 2'b10, cas = 2'b11, we = 2'b11, out_ba = 6'b101101, out_a holds 0x1234 in both slots. Then 3 NOP cycles, done pulses once, busy = 0, cmd_ready returns high.
- Four WR commands with dly = 0 and valid held high -> four consecutive ISSUE cycles with cas/we first-slot = 0, cmd_ready never drops, no NOP cycles between commands.
- MRS with cke = 1, odt = 1, dly = 0, then NOP with cke = 1, odt = 0 -> out_cke = 11 throughout, out_odt = 11 then 00 aligned to the second command.
- en dropped during a 5-cycle WAIT -> the WAIT finishes, no further accept while en = 0, out_tri remains 00 while busy is high.
- rst_n pulsed low in WAIT with count = 7 -> outputs immediately return to reset values, no done pulse, and a fresh command issues normally afterwards.

Source files
------------

// File: rtl/cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cmd_sequencer
//
// Command-issue stage that sits directly in front of the DDR3 command/address
// PHY. Encoded DDR3 commands arrive over a valid/ready handshake, each with its
// own NOP gap. Every signal toward the PHY is a two-slot pair per clk_div cycle:
// bit [2i] is the earlier clk slot and bit [2i+1] is the later one. A command
// is placed in the earlier slot and the later slot always carries a NOP.
//
// Ports
//   clk_div, rst_n          half-rate clock, asynchronous active-low reset
//   en                      sequencer enable (gates acceptance and out_tri)
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  {RAS,CAS,WE} active-low opcode (7 = NOP)
//   cmd_ba, cmd_a           bank / address for the command
//   cmd_cke, cmd_odt        CKE/ODT levels applied from this command on
//   cmd_dly                 extra NOP clk_div cycles after the command
//   cmd_last                final command of the sequence
//   out_*                   registered slot pairs toward the PHY
//   busy                    sequence in progress
//   done                    one-cycle pulse when the sequence ends
//
// Handshake: a command transfers on a rising clk_div edge where cmd_valid and
// cmd_ready are both high. cmd_ready is derived only from registered state and
// en, never from cmd_valid, so the upstream may hold cmd_valid and the command
// fields steady for as long as it likes without side effects; the fields must
// stay stable while cmd_valid is high and are sampled only at the transfer.
// -----------------------------------------------------------------------------
module cmd_sequencer #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int DELAY_WIDTH    = 10
) (
  input  logic                        clk_div,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [2:0]                  cmd_ba,
  input  logic [ADDRESS_NUMBER-1:0]   cmd_a,
  input  logic                        cmd_cke,
  input  logic                        cmd_odt,
  input  logic [DELAY_WIDTH-1:0]      cmd_dly,
  input  logic                        cmd_last,
  output logic [2*ADDRESS_NUMBER-1:0] out_a,
  output logic [5:0]                  out_ba,
  output logic [1:0]                  out_we,
  output logic [1:0]                  out_ras,
  output logic [1:0]                  out_cas,
  output logic [1:0]                  out_cke,
  output logic [1:0]                  out_odt,
  output logic [1:0]                  out_tri,
  output logic                        busy,
  output logic                        done
);

  // r_state names what the output registers currently present to the PHY.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      r_state, w_state_next;
  logic [DELAY_WIDTH-1:0]      r_count, w_count_next;
  logic                        r_last, w_last_next;
  logic                        r_busy, w_busy_next;
  logic                        r_done, w_done_next;

  logic [2*ADDRESS_NUMBER-1:0] r_a;
  logic [5:0]                  r_ba;
  logic [1:0]                  r_we, r_ras, r_cas;
  logic [1:0]                  r_cke, r_odt, r_tri;

  logic                        w_accept;
  logic                        w_cnt_le1;

  // r_last stays set from the accept of a last command until DONE is entered;
  // holding off acceptance meanwhile keeps the done pulse tied to its own
  // sequence even when the last command has no NOP gap.
  assign cmd_ready = en & (r_count == '0) & ~r_last;
  assign w_accept  = cmd_valid & cmd_ready;

  // The counter holds the NOP cycles still owed after the current cycle, so
  // the cycle in which it reads 0 is the final NOP and acceptance reopens
  // there. A gap of 0 or 1 both leave ISSUE straight for IDLE/DONE.
  assign w_cnt_le1 = (r_count <= DELAY_WIDTH'(1));

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_last_next  = r_last;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    if (r_count != '0) begin
      w_count_next = r_count - DELAY_WIDTH'(1);
    end

    case (r_state)
      S_ISSUE, S_WAIT: begin
        if (w_cnt_le1) begin
          w_state_next = r_last ? S_DONE : S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next == S_DONE) begin
      w_last_next = 1'b0;
      w_busy_next = 1'b0;
      w_done_next = 1'b1;
    end

    // An accept is only possible with the counter at 0 and no last pending,
    // so it never collides with a DONE entry above.
    if (w_accept) begin
      w_state_next = S_ISSUE;
      w_count_next = cmd_dly;
      w_last_next  = cmd_last;
      w_busy_next  = 1'b1;
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_last  <= w_last_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // PHY-facing pairs. Address and bank hold between commands; CKE/ODT are
  // sticky until the next accepted command (including a timed NOP).
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_ba  <= '0;
      r_ras <= 2'b11;
      r_cas <= 2'b11;
      r_we  <= 2'b11;
      r_cke <= 2'b00;
      r_odt <= 2'b00;
      r_tri <= 2'b11;
    end else begin
      r_tri <= {2{~en & ~r_busy}};
      if (w_accept) begin
        r_a   <= {2{cmd_a}};
        r_ba  <= {2{cmd_ba}};
        r_ras <= {1'b1, cmd_op[2]};
        r_cas <= {1'b1, cmd_op[1]};
        r_we  <= {1'b1, cmd_op[0]};
        r_cke <= {2{cmd_cke}};
        r_odt <= {2{cmd_odt}};
      end else begin
        r_ras <= 2'b11;
        r_cas <= 2'b11;
        r_we  <= 2'b11;
      end
    end
  end

  assign out_a   = r_a;
  assign out_ba  = r_ba;
  assign out_ras = r_ras;
  assign out_cas = r_cas;
  assign out_we  = r_we;
  assign out_cke = r_cke;
  assign out_odt = r_odt;
  assign out_tri = r_tri;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;

  localparam int AN     = 15;
  localparam int DW     = 10;
  localparam int FW     = 6 + 6 + 2*AN + 4;
  localparam int BUDGET = 3000;

  logic            clk_div = 1'b0;
  logic            rst_n;
  logic            en;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [2:0]      cmd_ba;
  logic [AN-1:0]   cmd_a;
  logic            cmd_cke;
  logic            cmd_odt;
  logic [DW-1:0]   cmd_dly;
  logic            cmd_last;
  logic [2*AN-1:0] out_a;
  logic [5:0]      out_ba;
  logic [1:0]      out_we, out_ras, out_cas, out_cke, out_odt, out_tri;
  logic            busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [FW-1:0] exp_q[$];
  int            issue_cyc[$];
  logic [FW-1:0] w_got;

  cmd_sequencer #(.ADDRESS_NUMBER(AN), .DELAY_WIDTH(DW)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ba(cmd_ba), .cmd_a(cmd_a),
    .cmd_cke(cmd_cke), .cmd_odt(cmd_odt), .cmd_dly(cmd_dly), .cmd_last(cmd_last),
    .out_a(out_a), .out_ba(out_ba), .out_we(out_we), .out_ras(out_ras),
    .out_cas(out_cas), .out_cke(out_cke), .out_odt(out_odt), .out_tri(out_tri),
    .busy(busy), .done(done)
  );

  // clock / reset block
  always #5 clk_div = ~clk_div;
  always @(posedge clk_div) cyc++;

  assign w_got = {out_ras, out_cas, out_we, out_ba, out_a, out_cke, out_odt};

  function automatic logic [FW-1:0] make_frame(input logic [2:0] op, input logic [2:0] ba,
                                               input logic [AN-1:0] a, input logic cke,
                                               input logic odt);
    return {1'b1, op[2], 1'b1, op[1], 1'b1, op[0], ba, ba, a, a, cke, cke, odt, odt};
  endfunction

  // scoreboard: every non-NOP slot pair seen out of reset must match the
  // oldest command that was handed over
  always @(negedge clk_div) begin
    if (rst_n === 1'b1 && {out_ras, out_cas, out_we} !== 6'b111111) begin
      logic [FW-1:0] e;
      issue_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_unexpected: got %h, expected no issue", w_got);
      end else begin
        e = exp_q.pop_front();
        if (w_got !== e) $display("FAIL issue_frame: got %h, expected %h", w_got, e);
        else n_pass++;
      end
    end
  end

  // driver: present a command, wait (bounded) for cmd_ready, hand the expected
  // frame to the scoreboard, and return just after the transfer edge
  task automatic send(input logic [2:0] op, input logic [2:0] ba, input logic [AN-1:0] a,
                      input logic cke, input logic odt, input logic [DW-1:0] dly,
                      input logic last, output int waited);
    bit ok;
    cmd_valid = 1'b1; cmd_op = op; cmd_ba = ba; cmd_a = a;
    cmd_cke = cke; cmd_odt = odt; cmd_dly = dly; cmd_last = last;
    waited = 0;
    ok = 1'b0;
    while (waited < BUDGET) begin
      @(negedge clk_div);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      waited++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: got no cmd_ready after %0d cycles, expected ready", waited);
      cmd_valid = 1'b0;
    end else begin
      if (op != 3'd7) exp_q.push_back(make_frame(op, ba, a, cke, odt));
      @(posedge clk_div); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < BUDGET) begin
      @(negedge clk_div);
      cycles++;
      if (done === 1'b1) return;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd7; cmd_ba = '0; cmd_a = '0;
    cmd_cke = 1'b0; cmd_odt = 1'b0; cmd_dly = '0; cmd_last = 1'b0;
    repeat (3) @(negedge clk_div);
    n_checks++;
    if ({out_ras, out_cas, out_we, out_cke, out_odt, out_tri} !== 12'b111111_00_00_11)
      $display("FAIL rst_pins: got %b, expected 111111000011",
               {out_ras, out_cas, out_we, out_cke, out_odt, out_tri});
    else n_pass++;
    n_checks++;
    if ({out_a, out_ba, busy, done} !== '0)
      $display("FAIL rst_addr: got a=%h ba=%b busy=%b done=%b, expected zeros", out_a, out_ba, busy, done);
    else n_pass++;
    @(posedge clk_div); #1;
    rst_n = 1'b1; en = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b, expected 1", cmd_ready); else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if (out_tri !== 2'b11) $display("FAIL tri_lag: got %b, expected 11", out_tri); else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if (out_tri !== 2'b00) $display("FAIL tri_en: got %b, expected 00", out_tri); else n_pass++;
    n_checks++;
    if ({out_ras, out_cas, out_we, out_cke, busy} !== 9'b111111_00_0)
      $display("FAIL idle_pins: got %b, expected 111111000", {out_ras, out_cas, out_we, out_cke, busy});
    else n_pass++;
  endtask

  task automatic test_act();
    int w, c;
    @(posedge clk_div); #1;
    send(3'd3, 3'd5, 15'h1234, 1'b0, 1'b0, 10'd3, 1'b1, w);
    @(negedge clk_div);
    n_checks++;
    if ({busy, cmd_ready, done} !== 3'b100)
      $display("FAIL act_issue_flags: got busy/ready/done %b, expected 100", {busy, cmd_ready, done});
    else n_pass++;
    n_checks++;
    if ({out_ras, out_cas, out_we, out_ba} !== 12'b10_11_11_101101)
      $display("FAIL act_pins: got %b, expected 101111101101", {out_ras, out_cas, out_we, out_ba});
    else n_pass++;
    wait_done(c);
    n_checks++;
    if (c !== 3) $display("FAIL act_gap: got done after %0d cycles, expected 3", c); else n_pass++;
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01)
      $display("FAIL act_end: got busy/ready %b, expected 01", {busy, cmd_ready});
    else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_pulse: got %b, expected 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w, c, base;
    @(posedge clk_div); #1;
    base = issue_cyc.size();
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 3'($urandom_range(0, 7)), 15'($urandom_range(0, 32767)), 1'b0, 1'b0, 10'd0,
           (i == 3), w);
      n_checks++;
      if (w !== 0) $display("FAIL b2b_ready%0d: got %0d stall cycles, expected 0", i, w); else n_pass++;
    end
    wait_done(c);
    n_checks++;
    if (c !== 2) $display("FAIL b2b_done: got %0d cycles, expected 2", c); else n_pass++;
    n_checks++;
    if (issue_cyc.size() !== base + 4) begin
      $display("FAIL b2b_count: got %0d issues, expected 4", issue_cyc.size() - base);
    end else if (issue_cyc[base+3] - issue_cyc[base] !== 3) begin
      $display("FAIL b2b_span: got %0d cycles, expected 3", issue_cyc[base+3] - issue_cyc[base]);
    end else n_pass++;
  endtask

  task automatic test_cke_odt();
    int w, w2;
    @(posedge clk_div); #1;
    send(3'd0, 3'd0, 15'h0520, 1'b1, 1'b1, 10'd0, 1'b0, w);
    send(3'd7, 3'd0, 15'h0520, 1'b1, 1'b0, 10'd0, 1'b1, w2);
    n_checks++;
    if (w2 !== 0) $display("FAIL nop_stall: got %0d, expected 0", w2); else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if ({out_cke, out_odt, busy} !== 5'b11_00_1)
      $display("FAIL nop_cke_odt: got %b, expected 11001", {out_cke, out_odt, busy});
    else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if ({done, out_cke} !== 3'b1_11)
      $display("FAIL nop_done: got done/cke %b, expected 111", {done, out_cke});
    else n_pass++;
  endtask

  task automatic test_en_drop();
    int w, c, bad;
    @(posedge clk_div); #1;
    send(3'd2, 3'd3, 15'h0abc, 1'b1, 1'b0, 10'd5, 1'b0, w);
    en = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_ba = 3'd1; cmd_a = 15'h0055; cmd_dly = '0; cmd_last = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_div);
      if ({cmd_ready, out_tri, busy} !== 4'b0_00_1) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL en_hold: got %0d bad cycles, expected 0", bad); else n_pass++;
    @(posedge clk_div); #1;
    en = 1'b1;
    send(3'd5, 3'd1, 15'h0055, 1'b1, 1'b0, 10'd0, 1'b1, w);
    n_checks++;
    if (w !== 0) $display("FAIL en_resume: got %0d stall cycles, expected 0", w); else n_pass++;
    wait_done(c);
    n_checks++;
    if (c !== 2) $display("FAIL en_done: got %0d cycles, expected 2", c); else n_pass++;
    @(posedge clk_div); #1;
    en = 1'b0;
    @(negedge clk_div);
    n_checks++;
    if (out_tri !== 2'b00) $display("FAIL tri_off_lag: got %b, expected 00", out_tri); else n_pass++;
    @(negedge clk_div);
    n_checks++;
    if (out_tri !== 2'b11) $display("FAIL tri_off: got %b, expected 11", out_tri); else n_pass++;
    @(posedge clk_div); #1;
    en = 1'b1;
    @(negedge clk_div);
    @(negedge clk_div);
    n_checks++;
    if (out_tri !== 2'b00) $display("FAIL tri_on: got %b, expected 00", out_tri); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w, c, bad;
    @(posedge clk_div); #1;
    send(3'd1, 3'd2, 15'h0f0f, 1'b1, 1'b1, 10'd10, 1'b1, w);
    repeat (4) @(negedge clk_div);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_ras, out_cas, out_we, out_cke, out_odt, out_tri, busy, done} !== 14'b111111_00_00_11_00)
      $display("FAIL mid_rst_pins: got %b, expected 11111100001100",
               {out_ras, out_cas, out_we, out_cke, out_odt, out_tri, busy, done});
    else n_pass++;
    n_checks++;
    if ({out_a, out_ba} !== '0) $display("FAIL mid_rst_addr: got %h %b, expected 0", out_a, out_ba);
    else n_pass++;
    @(posedge clk_div); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_div);
      if (done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL mid_rst_no_done: got %0d pulses, expected 0", bad); else n_pass++;
    @(posedge clk_div); #1;
    send(3'd5, 3'd6, 15'h7001, 1'b1, 1'b0, 10'd2, 1'b1, w);
    wait_done(c);
    n_checks++;
    if (c !== 3) $display("FAIL mid_rst_fresh: got %0d cycles, expected 3", c); else n_pass++;
  endtask

  task automatic test_max_dly();
    int w, c;
    @(posedge clk_div); #1;
    send(3'd6, 3'd0, 15'h0400, 1'b1, 1'b0, 10'd1023, 1'b1, w);
    wait_done(c);
    n_checks++;
    if (c !== 1024) $display("FAIL max_dly: got done after %0d cycles, expected 1024", c); else n_pass++;
  endtask

  task automatic test_random();
    int w, c, d;
    d = 0;
    @(posedge clk_div); #1;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 4);
      send(3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 15'($urandom_range(0, 32767)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'(d), (i == 7), w);
    end
    wait_done(c);
    n_checks++;
    if (c !== ((d > 1) ? d : 1) + 1)
      $display("FAIL rand_done: got %0d cycles, expected %0d", c, ((d > 1) ? d : 1) + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_act();
    test_back_to_back();
    test_cke_odt();
    test_en_drop();
    test_reset_mid();
    test_max_dly();
    test_random();
    repeat (3) @(negedge clk_div);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
